// File: rtl/xbar_pkg.sv
// -----------------------------------------------------------------------------
// xbar_pkg
// Shared crossbar constants for the response return path.
//   QTY_OF_DEVICES   : default number of masters and slaves (square crossbar)
//   DEVICE_ADDR_SIZE : bits needed to name one master
//   DATA_WIDTH       : default read-data width
//   master_idx_t     : type of a master index at the default crossbar size
// -----------------------------------------------------------------------------
package xbar_pkg;

    localparam int QTY_OF_DEVICES   = 4;
    localparam int DEVICE_ADDR_SIZE = $clog2(QTY_OF_DEVICES);
    localparam int DATA_WIDTH       = 32;

    typedef logic [DEVICE_ADDR_SIZE-1:0] master_idx_t;

endpackage

// File: rtl/response_return_router_if.sv
// -----------------------------------------------------------------------------
// response_return_router_if
// Bundles every per-slave and per-master signal of the response router.
//   s_accept_i / s_accept_master_i / s_accept_read_i : accepted-request notice
//   s_resp_i / s_rdata_i                             : slave read response
//   s_resp_ready_o                                   : router takes response
//   s_full_o                                         : slave tag FIFO is full
//   m_resp_o / m_rdata_o                             : response to each master
//   err_o                                            : sticky protocol error
// Modport slave is the router's view; modport master is the surrounding
// crossbar that feeds the router and consumes its outputs.
// -----------------------------------------------------------------------------
interface response_return_router_if #(
    parameter int N_DEV      = xbar_pkg::QTY_OF_DEVICES,
    parameter int DATA_WIDTH = xbar_pkg::DATA_WIDTH
);

    localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

    logic [N_DEV-1:0]                  s_accept_i;
    logic [N_DEV-1:0][IDX_W-1:0]       s_accept_master_i;
    logic [N_DEV-1:0]                  s_accept_read_i;
    logic [N_DEV-1:0]                  s_resp_i;
    logic [N_DEV-1:0][DATA_WIDTH-1:0]  s_rdata_i;
    logic [N_DEV-1:0]                  s_resp_ready_o;
    logic [N_DEV-1:0]                  s_full_o;
    logic [N_DEV-1:0]                  m_resp_o;
    logic [N_DEV-1:0][DATA_WIDTH-1:0]  m_rdata_o;
    logic                              err_o;

    modport slave (
        input  s_accept_i,
        input  s_accept_master_i,
        input  s_accept_read_i,
        input  s_resp_i,
        input  s_rdata_i,
        output s_resp_ready_o,
        output s_full_o,
        output m_resp_o,
        output m_rdata_o,
        output err_o
    );

    modport master (
        output s_accept_i,
        output s_accept_master_i,
        output s_accept_read_i,
        output s_resp_i,
        output s_rdata_i,
        input  s_resp_ready_o,
        input  s_full_o,
        input  m_resp_o,
        input  m_rdata_o,
        input  err_o
    );

endinterface

// File: rtl/tag_fifo.sv
// -----------------------------------------------------------------------------
// tag_fifo
// Small FIFO remembering which master each outstanding read belongs to.
//   clk, rst   : clock and synchronous active-high reset
//   push       : write push_data (ignored when full unless popping too)
//   push_data  : tag to store
//   pop        : drop the head entry (ignored when empty)
//   full/empty : occupancy flags
//   head       : oldest stored tag
// Pointers carry one extra wrap bit so full and empty are told apart without
// a separate counter. DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                     (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot this cycle, so a push while full is still taken.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[ADDR_W-1:0]];

    // Storage array; left unreset since empty/full guard every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= push_data;
        end
    end

    // Read and write pointers advance independently and wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/response_return_router.sv
// -----------------------------------------------------------------------------
// response_return_router
// Routes slave read responses back to the master that issued each read.
//   clk, rst : clock and synchronous active-high reset
//   bus      : response_return_router_if.slave (see interface for signals)
// Each slave owns a tag FIFO filled as its reads are accepted. A response pops
// the head tag and parks {tag, data} in that slave's hold register. Every
// cycle each master picks the lowest-index hold register aimed at it; the
// winner's data is registered onto m_resp_o/m_rdata_o. Losers simply wait,
// which back-pressures their slave through s_resp_ready_o.
// -----------------------------------------------------------------------------
module response_return_router #(
    parameter int N_DEV      = xbar_pkg::QTY_OF_DEVICES,
    parameter int DATA_WIDTH = xbar_pkg::DATA_WIDTH,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    response_return_router_if.slave bus
);

    import xbar_pkg::*;

    localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

    logic [N_DEV-1:0]                 fifo_push;
    logic [N_DEV-1:0]                 fifo_pop;
    logic [N_DEV-1:0]                 fifo_full;
    logic [N_DEV-1:0]                 fifo_empty;
    logic [N_DEV-1:0][IDX_W-1:0]      fifo_head;

    logic [N_DEV-1:0]                 resp_ready;
    logic [N_DEV-1:0]                 resp_xfer;
    logic [N_DEV-1:0]                 deliver;
    logic [N_DEV-1:0]                 overflow;
    logic [N_DEV-1:0]                 orphan;

    logic [N_DEV-1:0]                 hold_valid;
    logic [N_DEV-1:0][IDX_W-1:0]      hold_tag;
    logic [N_DEV-1:0][DATA_WIDTH-1:0] hold_data;

    logic [N_DEV-1:0]                 resp_next;
    logic [N_DEV-1:0][DATA_WIDTH-1:0] rdata_next;
    logic [N_DEV-1:0]                 m_resp_q;
    logic [N_DEV-1:0][DATA_WIDTH-1:0] m_rdata_q;
    logic                             err_q;

    // One tag FIFO per slave; only reads leave a tag behind.
    for (genvar s = 0; s < N_DEV; s++) begin : g_slave
        assign fifo_push[s] = bus.s_accept_i[s] & bus.s_accept_read_i[s];

        tag_fifo #(
            .WIDTH (IDX_W),
            .DEPTH (TAG_DEPTH)
        ) u_tag_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (fifo_push[s]),
            .push_data (bus.s_accept_master_i[s]),
            .pop       (fifo_pop[s]),
            .full      (fifo_full[s]),
            .empty     (fifo_empty[s]),
            .head      (fifo_head[s])
        );
    end

    // A hold register can take a new response if it is empty or is being
    // handed to its master this very cycle.
    assign resp_ready = ~hold_valid | deliver;
    assign resp_xfer  = bus.s_resp_i & resp_ready;
    assign fifo_pop   = resp_xfer & ~fifo_empty;
    assign overflow   = fifo_push & fifo_full & ~fifo_pop;
    assign orphan     = resp_xfer & fifo_empty;

    assign bus.s_resp_ready_o = resp_ready;
    assign bus.s_full_o       = fifo_full;
    assign bus.m_resp_o       = m_resp_q;
    assign bus.m_rdata_o      = m_rdata_q;
    assign bus.err_o          = err_q;

    // Fixed priority per master: a hold register wins unless a lower-index
    // valid hold register is aimed at the same master.
    always_comb begin
        deliver = hold_valid;
        for (int s = 0; s < N_DEV; s++) begin
            for (int j = 0; j < N_DEV; j++) begin
                if (j < s && hold_valid[j] && hold_tag[j] == hold_tag[s]) begin
                    deliver[s] = 1'b0;
                end
            end
        end
    end

    // Steer each winning hold register to its master; at most one winner per
    // master exists, so scan order does not matter. Idle masters keep data.
    always_comb begin
        resp_next  = '0;
        rdata_next = m_rdata_q;
        for (int s = 0; s < N_DEV; s++) begin
            if (deliver[s]) begin
                resp_next[hold_tag[s]]  = 1'b1;
                rdata_next[hold_tag[s]] = hold_data[s];
            end
        end
    end

    // Hold registers: load on a response that found a tag, otherwise clear
    // once delivered. A response with no tag is discarded here.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= '0;
            hold_tag   <= '0;
            hold_data  <= '0;
        end else begin
            for (int s = 0; s < N_DEV; s++) begin
                if (fifo_pop[s]) begin
                    hold_valid[s] <= 1'b1;
                    hold_tag[s]   <= fifo_head[s];
                    hold_data[s]  <= bus.s_rdata_i[s];
                end else if (deliver[s]) begin
                    hold_valid[s] <= 1'b0;
                end
            end
        end
    end

    // Registered master outputs and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_resp_q  <= '0;
            m_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            m_resp_q  <= resp_next;
            m_rdata_q <= rdata_next;
            err_q     <= err_q | (|overflow) | (|orphan);
        end
    end

endmodule

// File: doc/response_return_router.md
RESPONSE_RETURN_ROUTER -- requirements
Module: response_return_router

Interface
REQ-001 Parameter N_DEV, default 4: number of masters and number of slaves (square crossbar).
REQ-002 Parameter DATA_WIDTH, default 32: read-data width.
REQ-003 Parameter TAG_DEPTH, default 4, power of 2: per-slave outstanding-read tag FIFO depth.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: one clock; reset is synchronous and active-high.
REQ-006 Port s_accept_i, input, N_DEV: slave s accepted a request this cycle (req & ack).
REQ-007 Port s_accept_master_i, input, N_DEV x $clog2(N_DEV): index of the master whose request slave s accepted.
REQ-008 Port s_accept_read_i, input, N_DEV: the accepted request is a read.
REQ-009 Port s_resp_i, input, N_DEV: slave s presents a read response.
REQ-010 Port s_rdata_i, input, N_DEV x DATA_WIDTH: slave read data.
REQ-011 Port s_resp_ready_o, output, N_DEV: router can take slave s response this cycle.
REQ-012 Port s_full_o, output, N_DEV: slave s tag FIFO full; arbiter s shall withhold grants.
REQ-013 Port m_resp_o, output, N_DEV: one-cycle response pulse to master m.
REQ-014 Port m_rdata_o, output, N_DEV x DATA_WIDTH: read data to master m, valid with m_resp_o.
REQ-015 Port err_o, output, 1: sticky protocol-error flag.

Function
REQ-016 Tag push: s_accept_i[s] & s_accept_read_i[s] shall push s_accept_master_i[s] into FIFO s; writes shall push nothing.
REQ-017 Response handshake: a response transfers when s_resp_i[s] & s_resp_ready_o[s]; the head tag shall be popped and {tag, data} loaded into hold register s.
REQ-018 s_resp_ready_o[s] = !hold_valid[s] | hold s delivered this cycle (combinational).
REQ-019 Slave shall keep s_resp_i and s_rdata_i stable until s_resp_ready_o is high.
REQ-020 Delivery: per master m, among valid hold registers tagged m, the lowest slave index wins; the winning hold register clears and m_resp_o[m]/m_rdata_o[m] are registered high/loaded at the next edge.
REQ-021 Latency: uncontested response accepted in cycle t shall appear on m_resp_o in cycle t+2; sustained throughput one response per cycle per slave.
REQ-022 Losing hold registers keep their contents; no response is dropped or reordered per slave.
REQ-023 Different masters shall receive responses in the same cycle independently.
REQ-024 m_rdata_o[m] holds its last value when m_resp_o[m] is low.
REQ-025 Push and pop on the same FIFO in the same cycle shall both occur; count unchanged, legal even when full.
REQ-026 s_full_o[s] = (count == TAG_DEPTH); pointers are log2(TAG_DEPTH)+1 bits and wrap modulo 2*TAG_DEPTH.
REQ-027 Push while full with no pop: push dropped, err_o set.
REQ-028 Response transfer with FIFO s empty: response dropped, hold not loaded, err_o set.
REQ-029 err_o cleared only by rst.

Reset
REQ-030 On rst: all FIFOs empty, hold registers invalid, m_resp_o=0, m_rdata_o=0, err_o=0, s_full_o=0, s_resp_ready_o all 1 (from the first cycle after rst).
REQ-031 rst mid-operation: outstanding tags and held responses discarded; no m_resp_o pulse in the cycle after rst deasserts.

Structure
REQ-032 Package xbar_pkg shall hold QTY_OF_DEVICES, DEVICE_ADDR_SIZE, DATA_WIDTH and the master-index typedef; the module imports it.
REQ-033 Per-slave tag FIFO shall be one sub-module, tag_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, head), instantiated N_DEV times in a generate loop.

Verification
REQ-034 Read from M2 accepted at S1, S1 responds data 0xDEADBEEF next cycle -> m_resp_o[2] pulses once, two cycles after the response, m_rdata_o[2]=0xDEADBEEF.
REQ-035 M0 then M3 reads accepted at S0, S0 responds 0x11 then 0x22 -> M0 gets 0x11, M3 gets 0x22, in order.
REQ-036 S0 and S2 respond to M1 in the same cycle -> M1 gets S0 data first, S2 data next cycle; s_resp_ready_o[2] low for one cycle.
REQ-037 Four reads accepted at S3 with no responses -> s_full_o[3]=1; fifth accept with no pop -> err_o=1; fifth accept with a simultaneous response -> err_o stays 0.
REQ-038 S2 responds with no outstanding tag -> err_o=1, no m_resp_o pulse.
REQ-039 rst asserted with 3 tags outstanding -> all FIFOs empty, no m_resp_o pulse after rst; new read completes normally.
